// File: rtl/botones_gato_if.sv
// Button bundle between the raw board pushbuttons and the game controller.
// The slave side is the debouncer front end; the master side drives the raw buttons.
interface botones_gato_if;
  logic boton_arriba;
  logic boton_abajo;
  logic boton_izq;
  logic boton_der;
  logic boton_elige;
  logic boton_arriba_reg;
  logic boton_abajo_reg;
  logic boton_izq_reg;
  logic boton_der_reg;
  logic boton_elige_reg;
  logic boton_activo;

  modport master (
    output boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige,
    input  boton_arriba_reg, boton_abajo_reg, boton_izq_reg, boton_der_reg,
           boton_elige_reg, boton_activo
  );

  modport slave (
    input  boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige,
    output boton_arriba_reg, boton_abajo_reg, boton_izq_reg, boton_der_reg,
           boton_elige_reg, boton_activo
  );
endinterface

// File: rtl/botones_gato.sv
// Tic-tac-toe button front end: synchronize, debounce and edge-detect five
// pushbuttons, then emit one registered one-hot command pulse per press.
module botones_gato #(
  parameter int DEBOUNCE_MAX = 500000,
  parameter int CNT_W        = 20
) (
  input  logic          clk,
  input  logic          reset_all_n,
  botones_gato_if.slave bus
);
  localparam int NB = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  typedef enum logic {IDLE, HELD} state_t;

  // Bit order doubles as priority: elige (MSB) wins over arriba, abajo, izq, der
  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync_p0, sync_p1;
  logic [NB-1:0]    db, db_prev, press;
  logic [NB-1:0]    pulse, pulse_nx;
  logic [CNT_W-1:0] cnt [NB];
  state_t           state, state_nx;

  function automatic logic [NB-1:0] pick_one(input logic [NB-1:0] req);
    logic [NB-1:0] grant;
    grant = '0;
    for (int i = 0; i < NB; i++) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

  assign raw = {bus.boton_elige, bus.boton_arriba, bus.boton_abajo,
                bus.boton_izq, bus.boton_der};

  // Stage p0/p1: two-flop synchronizer, then per-button debounce counter
  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      db_prev <= db;
      for (int b = 0; b < NB; b++) begin
        if (sync_p1[b] == db[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          db[b]  <= sync_p1[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  assign press = db & ~db_prev;

  always_comb begin
    state_nx = state;
    pulse_nx = '0;
    case (state)
      IDLE: begin
        if (|press) begin
          pulse_nx = pick_one(press);
          state_nx = HELD;
        end
      end
      HELD: begin
        if (~|db) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p2: registered FSM state and command pulses
  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      state <= IDLE;
      pulse <= '0;
    end else begin
      state <= state_nx;
      pulse <= pulse_nx;
    end
  end

  assign bus.boton_elige_reg  = pulse[4];
  assign bus.boton_arriba_reg = pulse[3];
  assign bus.boton_abajo_reg  = pulse[2];
  assign bus.boton_izq_reg    = pulse[1];
  assign bus.boton_der_reg    = pulse[0];
  assign bus.boton_activo     = (state == HELD);
endmodule
